// File: rtl/steering_link_pkg.sv
// ---------------------------------------------------------------------------
// steering_link_pkg
// Shared definitions for the one-wire steering command link, used by both
// the transmitter and the receiver.
//   - link_state_t : receiver/transmitter frame state encoding
//   - DATA_BITS    : payload width (direction in degrees)
//   - START_BIT / STOP_BIT : line levels of the framing bits
//   - odd_parity9(): parity bit that makes d[8:0] plus parity an odd count
// ---------------------------------------------------------------------------
package steering_link_pkg;

  localparam int DATA_BITS = 9;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } link_state_t;

  // Returns the parity bit so that the nine data bits plus this bit hold an
  // odd number of ones.
  function automatic logic odd_parity9(input logic [DATA_BITS-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/link_sync2.sv
// ---------------------------------------------------------------------------
// link_sync2
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   i_clk  in  1  destination clock
//   i_rst  in  1  synchronous active-high reset (flops load RESET_VAL)
//   i_d    in  1  asynchronous input
//   o_q    out 1  synchronized output
// ---------------------------------------------------------------------------
module link_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; reset value matches the idle level of the line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/steering_link_rx.sv
// ---------------------------------------------------------------------------
// steering_link_rx
// Receiver for the one-wire steering command link. Recovers the 9-bit target
// direction from a start/9 data (LSB first)/odd parity/stop frame, rejects
// bad parity, bad stop bit and out-of-range values, and presents accepted
// values with a one-cycle strobe.
// Ports:
//   CLOCK_50         in   1  system clock, sole clock domain
//   reset            in   1  synchronous active-high reset
//   serial_in        in   1  asynchronous link line, idle high
//   direction_out    out  9  last accepted direction (degrees)
//   direction_valid  out  1  one-cycle pulse when direction_out updates
//   parity_error     out  1  one-cycle pulse on parity mismatch
//   frame_error      out  1  one-cycle pulse on a low stop bit
//   range_error      out  1  one-cycle pulse when value > MAX_DIRECTION
//   busy             out  1  high from start detection until frame end
// ---------------------------------------------------------------------------
module steering_link_rx
  import steering_link_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int MAX_DIRECTION = 359
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       serial_in,
  output logic [8:0] direction_out,
  output logic       direction_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       range_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [3:0]           IDX_LAST  = 4'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] MAX_DIR   = DATA_BITS'(MAX_DIRECTION);

  logic                 w_rx;
  link_state_t          r_state;
  logic                 r_prev;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [8:0]           r_dir;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_rerr;
  logic                 r_busy;

  link_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clk (CLOCK_50),
    .i_rst (reset),
    .i_d   (serial_in),
    .o_q   (w_rx)
  );

  // Frame FSM: bit timing, data capture, frame evaluation and output strobes.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= IDLE;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_idx   <= 4'd0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_dir   <= 9'd0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_rerr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_rerr  <= 1'b0;
      // Tracked in every state so an edge right after returning to IDLE is
      // still seen as an edge.
      r_prev  <= w_rx;

      case (r_state)
        IDLE: begin
          if (r_prev && (w_rx == START_BIT)) begin
            r_state <= START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (w_rx == START_BIT) begin
              r_state <= DATA;
              r_idx   <= 4'd0;
            end else begin
              // Start pulse shorter than half a bit: treat as a glitch.
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            if (r_idx == IDX_LAST) begin
              r_state <= PARITY;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        PARITY: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_par   <= w_rx;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            // Exactly one outcome per frame, in priority order.
            if (w_rx != STOP_BIT) begin
              r_ferr  <= 1'b1;
              r_state <= WAIT_IDLE;
            end else if (r_par != odd_parity9(r_shift)) begin
              r_perr  <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (r_shift > MAX_DIR) begin
              r_rerr  <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_dir   <= r_shift;
              r_valid <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        WAIT_IDLE: begin
          // Only a full bit time of continuous high re-arms start detection,
          // so we never resync inside a broken frame.
          if (w_rx != STOP_BIT) begin
            r_cnt <= '0;
          end else if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign direction_out   = r_dir;
  assign direction_valid = r_valid;
  assign parity_error    = r_perr;
  assign frame_error     = r_ferr;
  assign range_error     = r_rerr;
  assign busy            = r_busy;

endmodule

// File: tb/tb_steering_link_rx.sv
// ---------------------------------------------------------------------------
// tb_steering_link_rx
// Self-checking bench for steering_link_rx at default parameters
// (434 clocks per bit). A table of frames is sent and the strobe counts and
// direction_out are compared after each; hand-written sequences cover the
// stop-bit failure with WAIT_IDLE, a short glitch and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_steering_link_rx;

  localparam int CPB = 50_000_000 / 115200;

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic [8:0] direction_out;
  logic       direction_valid;
  logic       parity_error;
  logic       frame_error;
  logic       range_error;
  logic       busy;

  steering_link_rx dut (
    .CLOCK_50        (clk),
    .reset           (reset),
    .serial_in       (serial_in),
    .direction_out   (direction_out),
    .direction_valid (direction_valid),
    .parity_error    (parity_error),
    .frame_error     (frame_error),
    .range_error     (range_error),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Strobe monitors: count cycles each strobe is high, so stretched pulses
  // show up as extra counts.
  int n_valid = 0;
  int n_perr  = 0;
  int n_ferr  = 0;
  int n_rerr  = 0;

  always @(negedge clk) begin
    if (direction_valid) n_valid <= n_valid + 1;
    if (parity_error)    n_perr  <= n_perr + 1;
    if (frame_error)     n_ferr  <= n_ferr + 1;
    if (range_error)     n_rerr  <= n_rerr + 1;
  end

  int total  = 0;
  int passed = 0;
  int s_valid, s_perr, s_ferr, s_rerr;

  typedef struct {
    logic [8:0] val;
    logic       pflip;
    logic       stop;
    int         gap;
    logic [8:0] dir;
    int         nv;
    int         np;
    int         nf;
    int         nr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act == exp) begin
      passed = passed + 1;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic snap();
    s_valid = n_valid;
    s_perr  = n_perr;
    s_ferr  = n_ferr;
    s_rerr  = n_rerr;
  endtask

  task automatic chk_strobes(input string tag, input int ev, input int ep,
                             input int ef, input int er);
    chk({tag, " valid"},  n_valid - s_valid, ev);
    chk({tag, " parity"}, n_perr - s_perr, ep);
    chk({tag, " frame"},  n_ferr - s_ferr, ef);
    chk({tag, " range"},  n_rerr - s_rerr, er);
  endtask

  task automatic drive_bit(input logic b, input int cycles);
    serial_in = b;
    repeat (cycles) @(negedge clk);
  endtask

  // Full frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [8:0] v, input logic pflip, input logic stop);
    logic p;
    p = ~(^v) ^ pflip;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 9; i++) drive_bit(v[i], CPB);
    drive_bit(p, CPB);
    drive_bit(stop, CPB);
  endtask

  initial begin
    int busy_low_at;
    logic [8:0] part;

    serial_in = 1'b1;
    reset     = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset dir", direction_out, 0);
    chk("reset busy", busy, 0);
    chk("reset strobes", n_valid + n_perr + n_ferr + n_rerr, 0);

    //          val    pflip stop  gap      dir  v  p  f  r
    vecs[0] = '{9'd90,  1'b0, 1'b1, 0,       9'd90,  1, 0, 0, 0};
    vecs[1] = '{9'd359, 1'b0, 1'b1, 0,       9'd359, 1, 0, 0, 0};
    vecs[2] = '{9'd360, 1'b0, 1'b1, 0,       9'd359, 0, 0, 0, 1};
    vecs[3] = '{9'd45,  1'b1, 1'b1, 0,       9'd359, 0, 1, 0, 0};
    vecs[4] = '{9'd0,   1'b0, 1'b1, 0,       9'd0,   1, 0, 0, 0};
    vecs[5] = '{9'd511, 1'b0, 1'b1, 0,       9'd0,   0, 0, 0, 1};
    vecs[6] = '{9'd256, 1'b0, 1'b1, 0,       9'd256, 1, 0, 0, 0};
    vecs[7] = '{9'd511, 1'b1, 1'b1, 0,       9'd256, 0, 1, 0, 0};
    vecs[8] = '{9'd300, 1'b1, 1'b0, CPB+20,  9'd256, 0, 0, 1, 0};
    vecs[9] = '{9'd5,   1'b0, 1'b1, 0,       9'd5,   1, 0, 0, 0};

    for (int k = 0; k < 10; k++) begin
      snap();
      send_frame(vecs[k].val, vecs[k].pflip, vecs[k].stop);
      if (vecs[k].gap > 0) drive_bit(1'b1, vecs[k].gap);
      chk_strobes($sformatf("vec%0d", k), vecs[k].nv, vecs[k].np, vecs[k].nf, vecs[k].nr);
      chk($sformatf("vec%0d dir", k), direction_out, vecs[k].dir);
    end

    // Stop bit low, line held low 3 more bit times, then released.
    repeat (CPB) @(negedge clk);
    snap();
    send_frame(9'd180, 1'b0, 1'b0);
    drive_bit(1'b0, 3 * CPB);
    chk("ferr busy held low line", busy, 1);
    chk_strobes("ferr", 0, 0, 1, 0);
    chk("ferr dir kept", direction_out, 5);
    serial_in = 1'b1;
    busy_low_at = -1;
    for (int c = 1; c <= CPB + 10; c++) begin
      @(negedge clk);
      if (c == CPB - 2) chk("ferr busy before idle time", busy, 1);
      if (!busy && busy_low_at < 0) busy_low_at = c;
    end
    chk("ferr busy released", (busy_low_at >= CPB) && (busy_low_at <= CPB + 4), 1);
    snap();
    send_frame(9'd270, 1'b0, 1'b1);
    chk_strobes("after ferr 270", 1, 0, 0, 0);
    chk("after ferr dir", direction_out, 270);

    // 100-cycle glitch on an idle line.
    repeat (CPB) @(negedge clk);
    snap();
    busy_low_at = -1;
    serial_in = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 100) serial_in = 1'b1;
      if (c == 50) chk("glitch busy seen", busy, 1);
      if (c > 50 && !busy && busy_low_at < 0) busy_low_at = c;
    end
    chk("glitch busy low by 225", (busy_low_at > 0) && (busy_low_at <= 225), 1);
    chk_strobes("glitch", 0, 0, 0, 0);
    chk("glitch dir", direction_out, 270);

    // Reset in the middle of data bit 4 of a 200 frame.
    part = 9'd200;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(part[i], CPB);
    drive_bit(part[4], CPB / 2);
    chk("midframe busy", busy, 1);
    snap();
    reset     = 1'b1;
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst dir", direction_out, 0);
    chk("rst busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    chk("post rst busy", busy, 0);
    chk_strobes("post rst", 0, 0, 0, 0);
    snap();
    send_frame(9'd123, 1'b0, 1'b1);
    chk_strobes("123", 1, 0, 0, 0);
    chk("123 dir", direction_out, 123);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
